// File: rtl/axi4_sram_pkg.sv
// rtl/axi4_sram_pkg.sv - shared types and address stepping for the AXI4 SRAM responder
package axi4_sram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

    // WRAP bursts step like INCR; they are rejected beat by beat anyway.
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        if (burst == FIXED) begin
            return addr;
        end
        return addr + (64'd1 << size);
    endfunction

endpackage

// File: rtl/axi4_sram_responder_if.sv
// rtl/axi4_sram_responder_if.sv - AXI4 AW/W/B/AR/R bundle between a manager and the SRAM responder
interface axi4_sram_responder_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/sram_dp_bytewe.sv
// rtl/sram_dp_bytewe.sv - simple dual-port RAM, byte write enables, read-first, 1-cycle read latency
module sram_dp_bytewe #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 4096,
    localparam int STRB_W = DATA_W / 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Separate process: a same-word write lands after this read samples, so old data is returned.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4_sram_responder.sv
// rtl/axi4_sram_responder.sv - AXI4 subordinate backed by block RAM; one outstanding read and one write
// Independent write (AW/W/B) and read (AR/R) engines share only the dual-port RAM.
module axi4_sram_responder
    import axi4_sram_pkg::*;
#(
    parameter int                ID_W      = 6,
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 512,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic                  chipset_clk,
    input logic                  chipset_rst,
    axi4_sram_responder_if.slave s_axi
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return !diff[ADDR_W] && ((diff[ADDR_W-1:0] >> OFF_W) < ADDR_W'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                               input logic [1:0] burst);
        return ADDR_W'(next_addr(64'(a), size, burst));
    endfunction

    logic              ram_we;
    logic [IDX_W-1:0]  ram_widx;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_ridx;
    logic [DATA_W-1:0] ram_rdata;

    sram_dp_bytewe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (chipset_clk),
        .we    (ram_we),
        .waddr (ram_widx),
        .wdata (s_axi.wdata),
        .wstrb (s_axi.wstrb),
        .re    (ram_re),
        .raddr (ram_ridx),
        .rdata (ram_rdata)
    );

    wr_state_e         wr_state;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_beat;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    logic w_hs;
    logic w_ok;
    logic w_beat_err;

    assign w_hs       = wready_q && s_axi.wvalid;
    assign w_ok       = in_range(w_addr) && (w_burst != WRAP);
    assign w_beat_err = !w_ok || (s_axi.wlast != (w_beat == w_len));
    assign ram_we     = w_hs && w_ok;
    assign ram_widx   = idx_of(w_addr);

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            wr_state  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= OKAY;
            w_err     <= 1'b0;
            w_beat    <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (s_axi.awvalid && awready_q) begin
                        w_id      <= s_axi.awid;
                        w_addr    <= s_axi.awaddr;
                        w_len     <= s_axi.awlen;
                        w_size    <= s_axi.awsize;
                        w_burst   <= s_axi.awburst;
                        w_beat    <= '0;
                        w_err     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wr_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_beat <= w_beat + 8'd1;
                        w_addr <= step(w_addr, w_size, w_burst);
                        w_err  <= w_err || w_beat_err;
                        // Only wlast ends the burst, even when the beat count disagrees.
                        if (s_axi.wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= w_id;
                            bresp_q  <= (w_err || w_beat_err) ? SLVERR : OKAY;
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wr_state  <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    rd_state_e         rd_state;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [8:0]        r_issued;
    logic              arready_q;

    // q_* tracks the beat sitting in the RAM output register; sk_* is the older beat parked in the skid.
    logic              q_valid;
    logic              q_err;
    logic              q_last;
    logic              sk_valid;
    logic              sk_err;
    logic              sk_last;
    logic [DATA_W-1:0] sk_data;

    logic              ar_hs;
    logic              r_valid;
    logic              pop;
    logic              issue_next;
    logic [ADDR_W-1:0] rd_src_addr;
    logic [1:0]        rd_src_burst;
    logic              rd_src_err;
    logic              rd_src_last;
    logic [DATA_W-1:0] q_data;
    logic              out_last;
    logic              out_err;

    assign ar_hs        = arready_q && s_axi.arvalid;
    assign r_valid      = q_valid || sk_valid;
    assign pop          = r_valid && s_axi.rready;
    assign issue_next   = (rd_state == R_BURST) && (r_issued <= {1'b0, r_len}) && (!sk_valid || pop);
    assign ram_re       = ar_hs || issue_next;
    assign rd_src_addr  = ar_hs ? s_axi.araddr : r_addr;
    assign rd_src_burst = ar_hs ? s_axi.arburst : r_burst;
    assign rd_src_err   = !in_range(rd_src_addr) || (rd_src_burst == WRAP);
    assign rd_src_last  = ar_hs ? (s_axi.arlen == 8'd0) : (r_issued == {1'b0, r_len});
    assign ram_ridx     = idx_of(rd_src_addr);

    assign q_data   = q_err ? '0 : ram_rdata;
    assign out_last = sk_valid ? sk_last : q_last;
    assign out_err  = sk_valid ? sk_err : q_err;

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rid     = r_id;
    assign s_axi.rdata   = sk_valid ? sk_data : q_data;
    assign s_axi.rlast   = r_valid && out_last;
    assign s_axi.rresp   = (r_valid && out_err) ? SLVERR : OKAY;

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b1;
            r_id      <= '0;
            q_valid   <= 1'b0;
            q_err     <= 1'b0;
            q_last    <= 1'b0;
            sk_valid  <= 1'b0;
            sk_err    <= 1'b0;
            sk_last   <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_id      <= s_axi.arid;
                        r_len     <= s_axi.arlen;
                        r_size    <= s_axi.arsize;
                        r_burst   <= s_axi.arburst;
                        r_addr    <= step(s_axi.araddr, s_axi.arsize, s_axi.arburst);
                        r_issued  <= 9'd1;
                        arready_q <= 1'b0;
                        rd_state  <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (issue_next) begin
                        r_addr   <= step(r_addr, r_size, r_burst);
                        r_issued <= r_issued + 9'd1;
                    end
                    if (pop && out_last) begin
                        arready_q <= 1'b1;
                        rd_state  <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase

            // A new RAM read overwrites the output register, so an unconsumed beat moves to the skid.
            if (ram_re) begin
                q_valid <= 1'b1;
                q_err   <= rd_src_err;
                q_last  <= rd_src_last;
                if (sk_valid || (q_valid && !pop)) begin
                    sk_valid <= 1'b1;
                    sk_data  <= q_data;
                    sk_err   <= q_err;
                    sk_last  <= q_last;
                end
            end else if (pop) begin
                if (sk_valid) begin
                    sk_valid <= 1'b0;
                end else begin
                    q_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_sram_responder.sv
// tb/tb_axi4_sram_responder.sv - directed and randomized bursts against a word-array memory model
module tb_axi4_sram_responder;

    localparam int          ID_W   = 6;
    localparam int          ADDR_W = 64;
    localparam int          DATA_W = 512;
    localparam int          DEPTH  = 4096;
    localparam int          STRB_W = DATA_W / 8;
    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_sram_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi4_sram_responder #(
        .ID_W      (ID_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .chipset_clk (clk),
        .chipset_rst (rst),
        .s_axi       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] wbuf  [256];
    logic [STRB_W-1:0] sbuf  [256];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int j = 0; j < DATA_W / 32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input int k, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + 64'(k) * (64'd1 << size);
    endfunction

    function automatic bit ok_addr(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) / STRB_W < DEPTH);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) / STRB_W);
    endfunction

    task automatic do_write(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at);
        bit err;
        int t;
        logic [63:0] a;
        err = (last_at != int'(len)) || (burst == 2'b10);
        for (int k = 0; k <= last_at; k++) begin
            a = beat_addr(addr, k, size, burst);
            if (!ok_addr(a)) err = 1'b1;
            else if (burst != 2'b10) begin
                for (int b = 0; b < STRB_W; b++)
                    if (sbuf[k][b]) model[widx(a)][b*8 +: 8] = wbuf[k][b*8 +: 8];
            end
        end
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 50) begin @(negedge clk); t++; end
        check("aw_ready", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int k = 0; k <= last_at; k++) begin
            bus.wdata = wbuf[k]; bus.wstrb = sbuf[k]; bus.wlast = (k == last_at); bus.wvalid = 1'b1;
            t = 0;
            while (!bus.wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) check("w_ready_timeout", bus.wready, 1);
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        t = 0;
        while (!bus.bvalid && t < 50) begin @(negedge clk); t++; end
        check("bvalid", bus.bvalid, 1);
        check("bid", bus.bid, id);
        check("bresp", bus.bresp, err ? 2'b10 : 2'b00);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 50) begin @(negedge clk); t++; end
        check("ar_ready", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int rmode);
        int got, cyc, first, lastc;
        bit ok;
        logic [63:0] a;
        send_ar(id, addr, len, size, burst);
        got = 0; cyc = 0; first = -1; lastc = -1;
        while (got <= int'(len) && cyc < 600) begin
            bus.rready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.rvalid && bus.rready) begin
                a  = beat_addr(addr, got, size, burst);
                ok = ok_addr(a) && (burst != 2'b10);
                check("rid", bus.rid, id);
                check("rdata", bus.rdata, ok ? model[widx(a)] : '0);
                check("rresp", bus.rresp, ok ? 2'b00 : 2'b10);
                check("rlast", bus.rlast, got == int'(len));
                if (first < 0) first = cyc;
                lastc = cyc;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_beats", got, int'(len) + 1);
        check("r_no_extra", bus.rvalid, 0);
        if (rmode == 0) begin
            check("r_first_latency", first, 0);
            check("r_back_to_back", lastc - first, int'(len));
        end
    endtask

    initial begin
        int t, got;
        logic [63:0] a;
        int ln;
        logic [1:0] bu;

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_awready", bus.awready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_bid", bus.bid, 0);
        check("rst_rid", bus.rid, 0);

        // W offered before any AW must not be taken
        bus.wvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("w_before_aw", bus.wready, 0);
        bus.wvalid = 1'b0;

        // Fill the whole RAM so every later read has a known expectation
        for (int p = 0; p < DEPTH / 256; p++) begin
            for (int k = 0; k < 256; k++) begin wbuf[k] = rand_word(); sbuf[k] = '1; end
            do_write(6'(p), BASE + 64'(p) * 256 * STRB_W, 8'd255, 3'd6, 2'b01, 255);
        end

        // 1) four-beat INCR write and readback
        for (int k = 0; k < 4; k++) begin wbuf[k] = rand_word(); sbuf[k] = '1; end
        do_write(6'd5, BASE + 64'h40, 8'd3, 3'd6, 2'b01, 3);
        do_read(6'd5, BASE + 64'h40, 8'd3, 3'd6, 2'b01, 0);

        // 2) partial strobe over an all-ones word
        wbuf[0] = '1; sbuf[0] = '1;
        do_write(6'd1, BASE, 8'd0, 3'd6, 2'b01, 0);
        wbuf[0] = rand_word(); sbuf[0] = 64'h0F;
        do_write(6'd2, BASE, 8'd0, 3'd6, 2'b01, 0);
        do_read(6'd2, BASE, 8'd0, 3'd6, 2'b01, 0);

        // 3) eight beats under random backpressure, then at full rate
        for (int k = 0; k < 8; k++) begin wbuf[k] = rand_word(); sbuf[k] = '1; end
        do_write(6'd3, BASE + 64'h1000, 8'd7, 3'd6, 2'b01, 7);
        do_read(6'd3, BASE + 64'h1000, 8'd7, 3'd6, 2'b01, 1);
        do_read(6'd4, BASE + 64'h1000, 8'd7, 3'd6, 2'b01, 0);

        // 4) bursts crossing the top of the RAM, and one below the base
        a = BASE + 64'(DEPTH) * STRB_W - STRB_W;
        do_read(6'd7, a, 8'd1, 3'd6, 2'b01, 0);
        for (int k = 0; k < 2; k++) begin wbuf[k] = rand_word(); sbuf[k] = '1; end
        do_write(6'd8, a, 8'd1, 3'd6, 2'b01, 1);
        do_read(6'd8, a, 8'd0, 3'd6, 2'b01, 0);
        do_read(6'd10, BASE - 64'h40, 8'd0, 3'd6, 2'b01, 0);

        // 5) early wlast, recovery, and WRAP rejection
        for (int k = 0; k < 4; k++) begin wbuf[k] = rand_word(); sbuf[k] = '1; end
        do_write(6'd11, BASE + 64'h2000, 8'd3, 3'd6, 2'b01, 1);
        do_write(6'd12, BASE + 64'h2000, 8'd3, 3'd6, 2'b01, 3);
        for (int k = 0; k < 4; k++) wbuf[k] = rand_word();
        do_write(6'd13, BASE + 64'h2000, 8'd3, 3'd6, 2'b10, 3);
        do_read(6'd13, BASE + 64'h2000, 8'd3, 3'd6, 2'b01, 0);
        do_read(6'd14, BASE + 64'h2000, 8'd3, 3'd6, 2'b10, 1);

        // FIXED and narrow INCR bursts
        for (int k = 0; k < 4; k++) begin wbuf[k] = rand_word(); sbuf[k] = {$urandom, $urandom}; end
        do_write(6'd15, BASE + 64'h3000, 8'd3, 3'd6, 2'b00, 3);
        do_read(6'd15, BASE + 64'h3000, 8'd2, 3'd6, 2'b00, 0);
        for (int k = 0; k < 16; k++) begin wbuf[k] = rand_word(); sbuf[k] = 64'hFF << (8 * (k % 8)); end
        do_write(6'd16, BASE + 64'h3040, 8'd15, 3'd3, 2'b01, 15);
        do_read(6'd16, BASE + 64'h3040, 8'd15, 3'd3, 2'b01, 1);

        // 6) reset in the middle of a read burst
        send_ar(6'd20, BASE + 64'h1000, 8'd7, 3'd6, 2'b01);
        bus.rready = 1'b1;
        got = 0; t = 0;
        while (got < 2 && t < 20) begin
            if (bus.rvalid) got++;
            @(negedge clk);
            t++;
        end
        check("mid_beats_taken", got, 2);
        rst = 1'b1; bus.rready = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_arready", bus.arready, 1);
        rst = 1'b0;
        do_read(6'd9, BASE + 64'h1000, 8'd3, 3'd6, 2'b01, 0);

        // Randomized write/read pairs
        for (int it = 0; it < 12; it++) begin
            a  = BASE + 64'($urandom_range(0, DEPTH - 1)) * STRB_W;
            ln = $urandom_range(0, 7);
            bu = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            for (int k = 0; k <= ln; k++) begin wbuf[k] = rand_word(); sbuf[k] = {$urandom, $urandom}; end
            do_write(6'($urandom), a, 8'(ln), 3'd6, bu, ln);
            do_read(6'($urandom), a, 8'(ln), 3'd6, bu, int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
